// File: rtl/bsc_axiu_stridesplitter.sv
// AXI4 read splitter: cuts each AR burst into sub-bursts that never cross a STRIDE
// boundary, then merges the R responses back into one burst by masking inner RLASTs.
module bsc_axiu_stridesplitter #(
    parameter int          ADDR_WIDTH = 64,
    parameter int          ID_WIDTH   = 4,
    parameter int          DATA_WIDTH = 512,
    parameter logic [63:0] STRIDE     = 64'h2000,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    // Upstream AR
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    // Downstream AR
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    // Downstream R
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    // Upstream R
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    // FSM state for checkers: 0 = IDLE, 1 = ISSUE
    output logic [0:0]            dbg_state_o
);
    // Handshakes: a transfer happens on any rising clk edge where valid && ready.
    localparam int SW  = $clog2(STRIDE);
    localparam int FAW = $clog2(FIFO_DEPTH);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [8:0]            rem_q, rem_d;
    logic [2:0]            size_q, size_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;

    logic [FIFO_DEPTH-1:0] flag_q, flag_d;
    logic [FAW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [FAW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [FAW:0]          cnt_q, cnt_d;

    logic                  fifo_full, fifo_empty, fifo_ok, ar_on;
    logic [SW-1:0]         off;
    logic [SW:0]           span, bnd, rem_ext;
    logic [8:0]            sub;
    logic [ADDR_WIDTH-1:0] step;
    logic                  is_final, in_hs, out_hs, pop;

    assign fifo_full  = (cnt_q == (FAW+1)'(FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign fifo_ok    = !fifo_empty && !rst;
    assign ar_on      = (state_q == S_ISSUE) && !rst;

    // Beats left before the next STRIDE boundary, in units of the burst size.
    assign off     = cur_addr_q[SW-1:0];
    assign span    = STRIDE[SW:0] - {1'b0, off};
    assign bnd     = span >> size_q;
    assign rem_ext = {{(SW-8){1'b0}}, rem_q};
    assign sub     = (rem_ext <= bnd) ? rem_q : bnd[8:0];
    assign step    = {{(ADDR_WIDTH-9){1'b0}}, sub} << size_q;
    assign is_final = (rem_q == sub);

    assign s_axi_arready = (state_q == S_IDLE) && !rst;
    assign m_axi_arvalid = ar_on && !fifo_full;
    assign m_axi_araddr  = ar_on ? cur_addr_q : '0;
    assign m_axi_arlen   = ar_on ? 8'(sub - 9'd1) : 8'd0;
    assign m_axi_arsize  = ar_on ? size_q : 3'd0;
    assign m_axi_arid    = ar_on ? id_q : '0;

    assign in_hs  = s_axi_arvalid && s_axi_arready;
    assign out_hs = m_axi_arvalid && m_axi_arready;
    assign pop    = m_axi_rvalid && m_axi_rready && m_axi_rlast;

    assign s_axi_rdata  = m_axi_rdata;
    assign s_axi_rresp  = m_axi_rresp;
    assign s_axi_rid    = m_axi_rid;
    assign s_axi_rvalid = m_axi_rvalid && fifo_ok;
    assign m_axi_rready = s_axi_rready && fifo_ok;
    assign s_axi_rlast  = m_axi_rlast && fifo_ok && flag_q[rd_ptr_q];

    assign dbg_state_o = state_q;

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        rem_d      = rem_q;
        size_d     = size_q;
        id_d       = id_q;
        case (state_q)
            S_IDLE: begin
                if (in_hs) begin
                    cur_addr_d = s_axi_araddr;
                    rem_d      = {1'b0, s_axi_arlen} + 9'd1;
                    size_d     = s_axi_arsize;
                    id_d       = s_axi_arid;
                    state_d    = S_ISSUE;
                end
            end
            default: begin
                if (out_hs) begin
                    if (is_final) begin
                        state_d = S_IDLE;
                    end else begin
                        cur_addr_d = cur_addr_q + step;
                        rem_d      = rem_q - sub;
                    end
                end
            end
        endcase
    end

    // A pop in the same cycle never frees room for a push; fullness is registered.
    always_comb begin
        flag_d   = flag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (out_hs) begin
            flag_d[wr_ptr_q] = is_final;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (out_hs && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!out_hs && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cur_addr_q <= '0;
            rem_q      <= '0;
            size_q     <= '0;
            id_q       <= '0;
            flag_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            rem_q      <= rem_d;
            size_q     <= size_d;
            id_q       <= id_d;
            flag_q     <= flag_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_bsc_axiu_stridesplitter.sv
// Directed bench for bsc_axiu_stridesplitter: split addresses/lengths, RLAST merge,
// flag FIFO backpressure, AR stall stability and reset in the middle of a split.
module tb_bsc_axiu_stridesplitter;
    localparam int AW = 64;
    localparam int IW = 4;
    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] s_araddr;
    logic [7:0]    s_arlen;
    logic [2:0]    s_arsize;
    logic [IW-1:0] s_arid;
    logic          s_arvalid;
    logic          s_arready;
    logic [AW-1:0] m_araddr;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic [IW-1:0] m_arid;
    logic          m_arvalid;
    logic          m_arready;
    logic [DW-1:0] m_rdata;
    logic [1:0]    m_rresp;
    logic [IW-1:0] m_rid;
    logic          m_rlast;
    logic          m_rvalid;
    logic          m_rready;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_rresp;
    logic [IW-1:0] s_rid;
    logic          s_rlast;
    logic          s_rvalid;
    logic          s_rready;
    logic [0:0]    dbg_state;

    int total = 0;
    int bad   = 0;

    bsc_axiu_stridesplitter #(
        .ADDR_WIDTH(AW), .ID_WIDTH(IW), .DATA_WIDTH(DW),
        .STRIDE(64'h2000), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axi_araddr(s_araddr), .s_axi_arlen(s_arlen), .s_axi_arsize(s_arsize),
        .s_axi_arid(s_arid), .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready),
        .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen), .m_axi_arsize(m_arsize),
        .m_axi_arid(m_arid), .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
        .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rid(m_rid),
        .m_axi_rlast(m_rlast), .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready),
        .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp), .s_axi_rid(s_rid),
        .s_axi_rlast(s_rlast), .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ar(input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [IW-1:0] id, output bit ok);
        ok        = 1'b0;
        s_araddr  = addr;
        s_arlen   = len;
        s_arsize  = size;
        s_arid    = id;
        s_arvalid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (s_arready) ok = 1'b1;
            tick();
        end
        s_arvalid = 1'b0;
    endtask

    task automatic get_sub(output logic [AW-1:0] addr, output logic [7:0] len,
                           output logic [2:0] size, output logic [IW-1:0] id, output bit ok);
        ok   = 1'b0;
        addr = '0;
        len  = '0;
        size = '0;
        id   = '0;
        m_arready = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (m_arvalid) begin
                ok   = 1'b1;
                addr = m_araddr;
                len  = m_arlen;
                size = m_arsize;
                id   = m_arid;
            end
            tick();
        end
        m_arready = 1'b0;
    endtask

    // One downstream sub-burst of n beats; rlast driven on beat n.
    task automatic r_sub(input int n, output int nlast, output int last_idx, output int nbad);
        nlast    = 0;
        last_idx = -1;
        nbad     = 0;
        s_rready = 1'b1;
        m_rvalid = 1'b1;
        for (int i = 1; i <= n; i++) begin
            m_rlast = (i == n);
            m_rdata = DW'(i * 32'h01010101);
            m_rresp = 2'(i);
            #1;
            if (s_rlast) begin
                nlast++;
                last_idx = i;
            end
            if (!s_rvalid || !m_rready || s_rdata !== m_rdata || s_rresp !== m_rresp) nbad++;
            tick();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        s_rready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_rvalid = 1'b1;
        m_rlast  = 1'b1;
        s_rready = 1'b1;
        s_arvalid = 1'b1;
        tick();
        tick();
        total++;
        if (s_arready !== 1'b0 || m_arvalid !== 1'b0 || s_rvalid !== 1'b0 ||
            m_rready !== 1'b0 || s_rlast !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: arrdy=%b arvld=%b rvld=%b rrdy=%b rlast=%b required all 0",
                     s_arready, m_arvalid, s_rvalid, m_rready, s_rlast);
        end
        total++;
        if (m_araddr !== '0 || m_arlen !== 8'd0 || m_arsize !== 3'd0 || m_arid !== '0 ||
            dbg_state !== 1'b0) begin
            bad++;
            $display("FAIL reset_fields: addr=%h len=%0d size=%0d id=%0d st=%0d required 0",
                     m_araddr, m_arlen, m_arsize, m_arid, dbg_state);
        end
        s_arvalid = 1'b0;
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        s_rready = 1'b0;
        rst = 1'b0;
        #1;
        total++;
        if (s_arready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_arready: got %b required 1", s_arready);
        end
        tick();
    endtask

    task automatic test_split_two();
        bit ok;
        logic [AW-1:0] a;
        logic [7:0] l;
        logic [2:0] sz;
        logic [IW-1:0] id;
        int nl, li, nb;
        do_ar(64'h1F00, 8'd15, 3'd6, 4'd9, ok);
        total++;
        if (!ok || m_arvalid !== 1'b1) begin
            bad++;
            $display("FAIL two_latency: accepted=%0d arvalid=%b required 1/1", ok, m_arvalid);
        end
        get_sub(a, l, sz, id, ok);
        total++;
        if (!ok || a !== 64'h1F00 || l !== 8'd3 || sz !== 3'd6 || id !== 4'd9) begin
            bad++;
            $display("FAIL two_sub0: ok=%0d addr=%h len=%0d size=%0d id=%0d required 1f00/3/6/9",
                     ok, a, l, sz, id);
        end
        get_sub(a, l, sz, id, ok);
        total++;
        if (!ok || a !== 64'h2000 || l !== 8'd11) begin
            bad++;
            $display("FAIL two_sub1: ok=%0d addr=%h len=%0d required 2000/11", ok, a, l);
        end
        #1;
        total++;
        if (m_arvalid !== 1'b0 || s_arready !== 1'b1) begin
            bad++;
            $display("FAIL two_idle: arvalid=%b arready=%b required 0/1", m_arvalid, s_arready);
        end
        r_sub(4, nl, li, nb);
        total++;
        if (nl !== 0 || nb !== 0) begin
            bad++;
            $display("FAIL two_r0: rlast_count=%0d bad_beats=%0d required 0/0", nl, nb);
        end
        r_sub(12, nl, li, nb);
        total++;
        if (nl !== 1 || li !== 12 || nb !== 0) begin
            bad++;
            $display("FAIL two_r1: rlast_count=%0d at=%0d bad_beats=%0d required 1/12/0", nl, li, nb);
        end
    endtask

    task automatic test_exact_boundary();
        bit ok;
        logic [AW-1:0] a;
        logic [7:0] l;
        logic [2:0] sz;
        logic [IW-1:0] id;
        int nl, li, nb;
        do_ar(64'h1000, 8'd63, 3'd6, 4'd1, ok);
        get_sub(a, l, sz, id, ok);
        #1;
        total++;
        if (!ok || a !== 64'h1000 || l !== 8'd63 || m_arvalid !== 1'b0 || s_arready !== 1'b1) begin
            bad++;
            $display("FAIL exact_sub: ok=%0d addr=%h len=%0d arvalid=%b arready=%b required 1000/63/0/1",
                     ok, a, l, m_arvalid, s_arready);
        end
        r_sub(64, nl, li, nb);
        total++;
        if (nl !== 1 || li !== 64 || nb !== 0) begin
            bad++;
            $display("FAIL exact_r: rlast_count=%0d at=%0d bad_beats=%0d required 1/64/0", nl, li, nb);
        end
    endtask

    task automatic test_split_three();
        bit ok;
        logic [AW-1:0] a;
        logic [7:0] l;
        logic [2:0] sz;
        logic [IW-1:0] id;
        logic [AW-1:0] exp_a [3];
        logic [7:0] exp_l [3];
        int exp_n [3];
        int nl, li, nb;
        exp_a = '{64'h3000, 64'h4000, 64'h6000};
        exp_l = '{8'd63, 8'd127, 8'd63};
        exp_n = '{64, 128, 64};
        do_ar(64'h3000, 8'd255, 3'd6, 4'd2, ok);
        for (int k = 0; k < 3; k++) begin
            get_sub(a, l, sz, id, ok);
            total++;
            if (!ok || a !== exp_a[k] || l !== exp_l[k]) begin
                bad++;
                $display("FAIL three_sub%0d: ok=%0d addr=%h len=%0d required %h/%0d",
                         k, ok, a, l, exp_a[k], exp_l[k]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            r_sub(exp_n[k], nl, li, nb);
            total++;
            if (nl !== ((k == 2) ? 1 : 0) || nb !== 0) begin
                bad++;
                $display("FAIL three_r%0d: rlast_count=%0d bad_beats=%0d required %0d/0",
                         k, nl, nb, (k == 2) ? 1 : 0);
            end
        end
    endtask

    task automatic test_fifo_full();
        bit ok;
        logic [AW-1:0] a;
        logic [7:0] l;
        logic [2:0] sz;
        logic [IW-1:0] id;
        int nl, li, nb, stuck;
        for (int k = 0; k < 4; k++) begin
            do_ar(AW'(k * 64), 8'd0, 3'd6, 4'd3, ok);
            get_sub(a, l, sz, id, ok);
        end
        do_ar(64'h0140, 8'd0, 3'd6, 4'd3, ok);
        m_arready = 1'b1;
        stuck = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (m_arvalid !== 1'b0 || s_arready !== 1'b0) stuck++;
            tick();
        end
        m_arready = 1'b0;
        total++;
        if (!ok || stuck !== 0) begin
            bad++;
            $display("FAIL full_hold: accepted=%0d cycles_with_arvalid=%0d required 1/0", ok, stuck);
        end
        r_sub(1, nl, li, nb);
        #1;
        total++;
        if (m_arvalid !== 1'b1 || nl !== 1) begin
            bad++;
            $display("FAIL full_release: arvalid=%b rlast_count=%0d required 1/1", m_arvalid, nl);
        end
        get_sub(a, l, sz, id, ok);
        total++;
        if (!ok || a !== 64'h0140 || l !== 8'd0) begin
            bad++;
            $display("FAIL full_sub: ok=%0d addr=%h len=%0d required 140/0", ok, a, l);
        end
        stuck = 0;
        for (int k = 0; k < 4; k++) begin
            r_sub(1, nl, li, nb);
            if (nl !== 1 || nb !== 0) stuck++;
        end
        total++;
        if (stuck !== 0) begin
            bad++;
            $display("FAIL full_drain: bad_bursts=%0d required 0", stuck);
        end
    endtask

    task automatic test_ar_stall();
        bit ok;
        logic [AW-1:0] a;
        logic [7:0] l;
        logic [2:0] sz;
        logic [IW-1:0] id;
        int nl, li, nb, moved;
        do_ar(64'h1F00, 8'd15, 3'd6, 4'd5, ok);
        get_sub(a, l, sz, id, ok);
        moved = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (m_arvalid !== 1'b1 || m_araddr !== 64'h2000 || m_arlen !== 8'd11 ||
                s_arready !== 1'b0) moved++;
            tick();
        end
        total++;
        if (moved !== 0) begin
            bad++;
            $display("FAIL stall_stable: unstable_cycles=%0d required 0", moved);
        end
        get_sub(a, l, sz, id, ok);
        total++;
        if (!ok || a !== 64'h2000 || l !== 8'd11) begin
            bad++;
            $display("FAIL stall_sub1: ok=%0d addr=%h len=%0d required 2000/11", ok, a, l);
        end
        r_sub(4, nl, li, nb);
        moved = nl;
        r_sub(12, nl, li, nb);
        total++;
        if (moved !== 0 || nl !== 1 || li !== 12) begin
            bad++;
            $display("FAIL stall_r: rlast_first=%0d rlast_second=%0d at=%0d required 0/1/12",
                     moved, nl, li);
        end
    endtask

    task automatic test_reset_mid_split();
        bit ok;
        logic [AW-1:0] a;
        logic [7:0] l;
        logic [2:0] sz;
        logic [IW-1:0] id;
        int seen;
        do_ar(64'h1F00, 8'd15, 3'd6, 4'd7, ok);
        get_sub(a, l, sz, id, ok);
        rst = 1'b1;
        #1;
        total++;
        if (m_arvalid !== 1'b0 || s_arready !== 1'b0 || m_araddr !== '0 || m_arlen !== 8'd0) begin
            bad++;
            $display("FAIL midrst_during: arvalid=%b arready=%b addr=%h len=%0d required 0/0/0/0",
                     m_arvalid, s_arready, m_araddr, m_arlen);
        end
        tick();
        rst = 1'b0;
        m_arready = 1'b1;
        m_rvalid = 1'b1;
        m_rlast  = 1'b1;
        s_rready = 1'b1;
        #1;
        total++;
        if (s_arready !== 1'b1 || m_rready !== 1'b0 || s_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_after: arready=%b rready=%b rvalid=%b required 1/0/0",
                     s_arready, m_rready, s_rvalid);
        end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (m_arvalid !== 1'b0 || m_rready !== 1'b0) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL midrst_no_sub: cycles_with_activity=%0d required 0", seen);
        end
        m_arready = 1'b0;
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        s_rready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        s_araddr = '0;
        s_arlen = '0;
        s_arsize = '0;
        s_arid = '0;
        s_arvalid = 1'b0;
        m_arready = 1'b0;
        m_rdata = '0;
        m_rresp = '0;
        m_rid = '0;
        m_rlast = 1'b0;
        m_rvalid = 1'b0;
        s_rready = 1'b0;
        test_reset();
        test_split_two();
        test_exact_boundary();
        test_split_three();
        test_fifo_full();
        test_ar_stall();
        test_reset_mid_split();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
